// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - KxK sliding-window generator over a raster pixel stream
// Optional macro CONV_WIN_COORD_EN adds Out_Row/Out_Col output-map coordinates.
module conv_window_gen #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int K          = 3,
  parameter int STRIDE_X   = 1,
  parameter int STRIDE_Y   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Valid_In,
  input  logic [DATA_WIDHT-1:0]        Data_In,
  output logic [K*K*DATA_WIDHT-1:0]    Window_Out,
  output logic                         Valid_Out,
  output logic                         Frame_Done
`ifdef CONV_WIN_COORD_EN
  ,
  output logic [15:0]                  Out_Row,
  output logic [15:0]                  Out_Col
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    px, py, px_cur, py_cur, px_nxt, py_nxt;
  logic          col_last, row_last, emit;

  logic [DATA_WIDHT-1:0] line_buf [K-1][IMG_WIDTH];
  logic [DATA_WIDHT-1:0] win      [K][K];
  logic [DATA_WIDHT-1:0] win_nxt  [K][K];

  // Phase counters are forced to 0 at the first window position so stale phase never gates
  always_comb begin
    px_cur   = (col == CW'(K-1)) ? 3'd0 : px;
    py_cur   = (row == RW'(K-1)) ? 3'd0 : py;
    px_nxt   = (px_cur == 3'(STRIDE_X-1)) ? 3'd0 : px_cur + 3'd1;
    py_nxt   = (py_cur == 3'(STRIDE_Y-1)) ? 3'd0 : py_cur + 3'd1;
    col_last = (col == CW'(IMG_WIDTH-1));
    row_last = (row == RW'(IMG_HEIGHT-1));
    emit     = Valid_In && (row >= RW'(K-1)) && (col >= CW'(K-1))
               && (px_cur == 3'd0) && (py_cur == 3'd0);
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < K-1; r++) begin
      win_nxt[r][K-1] = line_buf[K-2-r][col];
    end
    win_nxt[K-1][K-1] = Data_In;
  end

  // line_buf[0] holds the previous row, line_buf[K-2] the oldest
  always_ff @(posedge clk) begin
    if (Valid_In) begin
      line_buf[0][col] <= Data_In;
      for (int j = 1; j < K-1; j++) begin
        line_buf[j][col] <= line_buf[j-1][col];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      px         <= '0;
      py         <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
      Window_Out <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      Valid_Out  <= emit;
      Frame_Done <= Valid_In && col_last && row_last;
      if (Valid_In) begin
        win <= win_nxt;
        px  <= px_nxt;
        col <= col_last ? '0 : col + CW'(1);
        if (col_last) begin
          row <= row_last ? '0 : row + RW'(1);
          py  <= py_nxt;
        end
      end
      if (emit) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            Window_Out[(r*K+c)*DATA_WIDHT +: DATA_WIDHT] <= win_nxt[r][c];
          end
        end
      end
    end
  end

`ifdef CONV_WIN_COORD_EN
  logic [15:0] ox, oy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ox      <= '0;
      oy      <= '0;
      Out_Row <= '0;
      Out_Col <= '0;
    end else if (Valid_In) begin
      if (emit) begin
        Out_Row <= oy;
        Out_Col <= ox;
        ox      <= ox + 16'd1;
      end
      // Only rows that produced windows advance the output row
      if (col_last) begin
        ox <= '0;
        if (row_last) begin
          oy <= '0;
        end else if ((row >= RW'(K-1)) && (py_cur == 3'd0)) begin
          oy <= oy + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen
// Covers 5x5 stride 1/2, bubbles, back-to-back frames, async reset and the 220x220 default.
module tb_conv_window_gen;

  localparam int KB = 3;
  localparam int WW = KB*KB*32;
  typedef logic [WW-1:0] win_t;
  typedef struct { win_t win; int trig; int oy; int ox; } exp_t;
  typedef struct { string name; int pct; int frames; int exp_cnt; int exp_fd; int spot; int e[9]; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_v, b_v, c_v;
  logic [31:0] a_d, b_d, c_d;
  win_t a_w, b_w, c_w;
  logic a_vo, b_vo, c_vo, a_fd, b_fd, c_fd;
  logic [15:0] a_or, a_oc, b_or, b_oc, c_or, c_oc;
  int a_idx = -1, b_idx = -1, c_idx = -1;
  int a_app = -1, b_app = -1, c_app = -1;

  int n_cmp = 0, n_bad = 0;
  exp_t qa[$], qb[$], qc[$];
  win_t cap_a[$];
  win_t c_first;
  int fd_a = 0, fd_b = 0, fd_c = 0, cnt_b = 0, cnt_c = 0, c_bad = 0;

  conv_window_gen #(.DATA_WIDHT(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .K(3), .STRIDE_X(1), .STRIDE_Y(1)) u_a (
    .clk(clk), .rst(rst), .Valid_In(a_v), .Data_In(a_d), .Window_Out(a_w), .Valid_Out(a_vo), .Frame_Done(a_fd)
`ifdef CONV_WIN_COORD_EN
    , .Out_Row(a_or), .Out_Col(a_oc)
`endif
  );

  conv_window_gen #(.DATA_WIDHT(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .K(3), .STRIDE_X(2), .STRIDE_Y(2)) u_b (
    .clk(clk), .rst(rst), .Valid_In(b_v), .Data_In(b_d), .Window_Out(b_w), .Valid_Out(b_vo), .Frame_Done(b_fd)
`ifdef CONV_WIN_COORD_EN
    , .Out_Row(b_or), .Out_Col(b_oc)
`endif
  );

  conv_window_gen u_c (
    .clk(clk), .rst(rst), .Valid_In(c_v), .Data_In(c_d), .Window_Out(c_w), .Valid_Out(c_vo), .Frame_Done(c_fd)
`ifdef CONV_WIN_COORD_EN
    , .Out_Row(c_or), .Out_Col(c_oc)
`endif
  );

`ifndef CONV_WIN_COORD_EN
  assign a_or = '0; assign a_oc = '0;
  assign b_or = '0; assign b_oc = '0;
  assign c_or = '0; assign c_oc = '0;
`endif

  task automatic check(input string name, input win_t act, input win_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic win_t mkwin(input int e[9]);
    win_t w = '0;
    for (int i = 0; i < 9; i++) w[i*32 +: 32] = 32'(e[i]);
    return w;
  endfunction

  // Reference: every output position enumerated directly from image geometry
  task automatic push_exp(input int sel, input int base, input int w, input int h, input int sx, input int sy);
    exp_t e;
    for (int oy = 0; oy <= (h-KB)/sy; oy++) begin
      for (int ox = 0; ox <= (w-KB)/sx; ox++) begin
        e.trig = (oy*sy + KB-1)*w + ox*sx + KB-1;
        e.oy = oy;
        e.ox = ox;
        e.win = '0;
        for (int r = 0; r < KB; r++)
          for (int c = 0; c < KB; c++)
            e.win[(r*KB+c)*32 +: 32] = 32'(base + (oy*sy + r)*w + ox*sx + c);
        case (sel)
          0: qa.push_back(e);
          1: qb.push_back(e);
          default: qc.push_back(e);
        endcase
      end
    end
  endtask

  task automatic mon(input int sel, input win_t w, input int app, input logic [15:0] orow, input logic [15:0] ocol);
    exp_t e;
    if (sel == 2) begin
      if (cnt_c == 0) c_first = w;
      cnt_c++;
      if (qc.size() == 0) c_bad++;
      else begin
        e = qc.pop_front();
        if (w !== e.win || app != e.trig) c_bad++;
      end
      return;
    end
    if (sel == 0) cap_a.push_back(w);
    else cnt_b++;
    if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_extra_pulse: got pulse after pixel %0d expected none", sel == 0 ? "a" : "b", app);
      return;
    end
    if (sel == 0) e = qa.pop_front();
    else e = qb.pop_front();
    check(sel == 0 ? "a_window" : "b_window", w, e.win);
    check(sel == 0 ? "a_trigger_pixel" : "b_trigger_pixel", win_t'(app), win_t'(e.trig));
`ifdef CONV_WIN_COORD_EN
    check(sel == 0 ? "a_out_row" : "b_out_row", win_t'(orow), win_t'(e.oy));
    check(sel == 0 ? "a_out_col" : "b_out_col", win_t'(ocol), win_t'(e.ox));
`else
    if (orow != ocol) begin end
`endif
  endtask

  always @(posedge clk) begin
    a_app <= a_idx;
    b_app <= b_idx;
    c_app <= c_idx;
  end

  always @(negedge clk) begin
    if (a_vo) mon(0, a_w, a_app, a_or, a_oc);
    if (b_vo) mon(1, b_w, b_app, b_or, b_oc);
    if (c_vo) mon(2, c_w, c_app, c_or, c_oc);
    if (a_fd) begin fd_a++; check("a_fd_pixel", win_t'(a_app), win_t'(24)); end
    if (b_fd) begin fd_b++; check("b_fd_pixel", win_t'(b_app), win_t'(24)); end
    if (c_fd) begin fd_c++; check("c_fd_pixel", win_t'(c_app), win_t'(220*220-1)); end
  end

  task automatic set_in(input int sel, input logic v, input logic [31:0] d, input int idx);
    case (sel)
      0: begin a_v = v; a_d = d; a_idx = idx; end
      1: begin b_v = v; b_d = d; b_idx = idx; end
      default: begin c_v = v; c_d = d; c_idx = idx; end
    endcase
  endtask

  task automatic drive(input int sel, input int base, input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      while (pct > 0 && $urandom_range(99) < pct) begin
        @(posedge clk); #1 set_in(sel, 1'b0, 32'h0, -1);
      end
      @(posedge clk); #1 set_in(sel, 1'b1, 32'(base + i), i);
    end
  endtask

  task automatic idle(input int sel, input int cycles);
    @(posedge clk); #1 set_in(sel, 1'b0, 32'h0, -1);
    repeat (cycles) @(posedge clk);
  endtask

  vec_t vecs[3];
  int cbase;
  int e0[9];

  initial begin
    vecs[0] = '{"s1_plain",   0,  1, 9,  1, 8, '{12, 13, 14, 17, 18, 19, 22, 23, 24}};
    vecs[1] = '{"s1_bubbles", 40, 1, 9,  1, 0, '{0, 1, 2, 5, 6, 7, 10, 11, 12}};
    vecs[2] = '{"b2b_frames", 0,  2, 18, 2, 9, '{100, 101, 102, 105, 106, 107, 110, 111, 112}};

    rst = 1'b0;
    set_in(0, 1'b0, 32'h0, -1);
    set_in(1, 1'b0, 32'h0, -1);
    set_in(2, 1'b0, 32'h0, -1);
    #1;
    check("reset_valid_out", win_t'(a_vo), '0);
    check("reset_frame_done", win_t'(a_fd), '0);
    check("reset_window", a_w, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // stride 2x2
    push_exp(1, 0, 5, 5, 2, 2);
    drive(1, 0, 25, 0);
    idle(1, 4);
    check("b_window_count", win_t'(cnt_b), win_t'(4));
    check("b_frame_done_count", win_t'(fd_b), win_t'(1));
    check("b_missing_windows", win_t'(qb.size()), '0);

    foreach (vecs[k]) begin
      win_t got;
      cap_a.delete();
      qa.delete();
      fd_a = 0;
      for (int f = 0; f < vecs[k].frames; f++) push_exp(0, f*100, 5, 5, 1, 1);
      for (int f = 0; f < vecs[k].frames; f++) drive(0, f*100, 25, vecs[k].pct);
      idle(0, 4);
      check({vecs[k].name, "_count"}, win_t'(cap_a.size()), win_t'(vecs[k].exp_cnt));
      check({vecs[k].name, "_frame_done"}, win_t'(fd_a), win_t'(vecs[k].exp_fd));
      got = (cap_a.size() > vecs[k].spot) ? cap_a[vecs[k].spot] : '0;
      check({vecs[k].name, "_spot_window"}, got, mkwin(vecs[k].e));
      check({vecs[k].name, "_missing"}, win_t'(qa.size()), '0);
    end

    // asynchronous reset right after the window for pixel 13 is presented
    cap_a.delete();
    qa.delete();
    fd_a = 0;
    push_exp(0, 0, 5, 5, 1, 1);
    drive(0, 0, 14, 0);
    @(posedge clk); #1 set_in(0, 1'b0, 32'h0, -1);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("rst_mid_valid_out", win_t'(a_vo), '0);
    check("rst_mid_window", a_w, '0);
    check("rst_pre_windows", win_t'(cap_a.size()), win_t'(2));
    check("rst_pending", win_t'(qa.size()), win_t'(7));
    qa.delete();
    cap_a.delete();
    @(posedge clk); #1 rst = 1'b1;
    push_exp(0, 200, 5, 5, 1, 1);
    drive(0, 200, 25, 0);
    idle(0, 4);
    e0 = '{200, 201, 202, 205, 206, 207, 210, 211, 212};
    check("rst_restart_count", win_t'(cap_a.size()), win_t'(9));
    check("rst_restart_first", cap_a.size() > 0 ? cap_a[0] : '0, mkwin(e0));
    check("rst_frame_done", win_t'(fd_a), win_t'(1));

    // default geometry, float-like pixel words
    cbase = 32'h4000_0000;
    push_exp(2, cbase, 220, 220, 1, 1);
    drive(2, cbase, 220*220, 0);
    idle(2, 4);
    e0 = '{cbase, cbase+1, cbase+2, cbase+220, cbase+221, cbase+222, cbase+440, cbase+441, cbase+442};
    check("c_window_count", win_t'(cnt_c), win_t'(47524));
    check("c_bad_windows", win_t'(c_bad), '0);
    check("c_frame_done", win_t'(fd_c), win_t'(1));
    check("c_first_window", c_first, mkwin(e0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
